// File: rtl/spm_job_sequencer.sv
// SPM job sequencer: buffers operand pairs, launches each job on the serial-parallel
// multiplier, waits for done (with timeout), reads the two product halves and
// presents the 64-bit result on a valid/ready output.
`timescale 1ns/1ps

module spm_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [31:0]              op_mc,
  input  logic [31:0]              op_mp,
  output logic [31:0]              spm_mc,
  output logic [31:0]              spm_mp,
  output logic                     spm_start,
  output logic                     spm_prod_sel,
  input  logic                     spm_done,
  input  logic [31:0]              spm_prod,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [63:0]              res_prod,
  output logic                     res_timeout,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              job_count,
  output logic [7:0]               timeout_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  // Last WAIT cycle: the counter value that, once incremented, reaches TIMEOUT-1.
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_RD_LO, S_RD_HI, S_OUT
  } state_t;

  state_t          state, state_next;
  logic [31:0]     mem_mc [DEPTH];
  logic [31:0]     mem_mp [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push, pop;
  logic [CW-1:0]   wait_cnt;
  logic            rd_phase;      // 0 = settle cycle, 1 = capture cycle
  logic [63:0]     res_q;
  logic            timeout_q;
  logic            timeout_hit, job_done;

  assign op_ready    = (count != (AW+1)'(DEPTH));
  assign push        = op_valid && op_ready && !clear;
  assign fifo_count  = count;
  assign spm_start   = (state == S_LAUNCH);
  assign res_valid   = (state == S_OUT);
  assign res_prod    = res_valid ? res_q : 64'd0;
  assign res_timeout = res_valid && timeout_q;
  assign busy        = (state != S_IDLE);

  // Operand storage; written on push only.
  // NOTE: storage arrays carry no reset -- validity is tracked by count/pointers,
  // so resetting the data would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_mc[wr_ptr] <= op_mc;
      mem_mp[wr_ptr] <= op_mp;
    end
  end

  // FIFO pointers and occupancy; clear flushes everything.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Next-state and per-cycle event decode.
  // NOTE: every output of this block gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    timeout_hit = 1'b0;
    job_done    = 1'b0;
    case (state)
      S_IDLE:   if (count != '0) begin
                  pop        = 1'b1;
                  state_next = S_LAUNCH;
                end
      S_LAUNCH: state_next = S_WAIT;
      S_WAIT:   if (wait_cnt != '0 && spm_done) begin
                  // done may be stale in the first WAIT cycle; it wins over timeout after that
                  state_next = S_RD_LO;
                end else if (wait_cnt == WAIT_LAST) begin
                  timeout_hit = 1'b1;
                  state_next  = S_OUT;
                end
      S_RD_LO:  if (rd_phase) state_next = S_RD_HI;
      S_RD_HI:  if (rd_phase) state_next = S_OUT;
      S_OUT:    if (res_ready) begin
                  job_done   = !timeout_q;
                  state_next = S_IDLE;
                end
      default:  state_next = S_IDLE;
    endcase
    if (clear) begin
      state_next  = S_IDLE;
      pop         = 1'b0;
      timeout_hit = 1'b0;
      job_done    = 1'b0;
    end
  end

  // State register, SPM operand/select registers, result capture and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      spm_mc        <= '0;
      spm_mp        <= '0;
      spm_prod_sel  <= 1'b0;
      wait_cnt      <= '0;
      rd_phase      <= 1'b0;
      res_q         <= '0;
      timeout_q     <= 1'b0;
      job_count     <= '0;
      timeout_count <= '0;
    end else begin
      state        <= state_next;
      spm_prod_sel <= (state_next == S_RD_HI);
      rd_phase     <= !clear && !rd_phase && (state == S_RD_LO || state == S_RD_HI);
      if (pop) begin
        spm_mc <= mem_mc[rd_ptr];
        spm_mp <= mem_mp[rd_ptr];
      end
      if (state == S_LAUNCH) begin
        wait_cnt  <= '0;
        res_q     <= '0;
        timeout_q <= 1'b0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout_hit) begin
        res_q     <= '0;
        timeout_q <= 1'b1;
        if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
      end
      if (!clear && rd_phase && state == S_RD_LO) res_q[31:0]  <= spm_prod;
      if (!clear && rd_phase && state == S_RD_HI) res_q[63:32] <= spm_prod;
      if (job_done) job_count <= job_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_spm_job_sequencer.sv
// Self-checking bench for spm_job_sequencer: behavioural SPM model, expected-result
// queue filled from accepted operand pairs, and one task per scenario.
`timescale 1ns/1ps

module tb_spm_job_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [31:0] op_mc = '0, op_mp = '0;
  logic [31:0] spm_mc, spm_mp;
  logic        spm_start, spm_prod_sel;
  logic        spm_done = 1'b0;
  logic [31:0] spm_prod;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [63:0] res_prod;
  logic        res_timeout, busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [15:0] job_count;
  logic [7:0]  timeout_count;

  typedef struct {
    logic [63:0] prod;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0, n_errors = 0;
  int   cyc = 0, n_starts = 0, n_sel = 0, t_sel_first = -1;
  int   lat = 64;              // SPM done latency after start; 0 = never done
  bit   rand_lat = 1'b0, stale_mode = 1'b0;
  int   cur_lat = 0, spm_cnt = 0;
  logic [63:0] spm_prod_r = '0;

  spm_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .op_valid(op_valid), .op_ready(op_ready), .op_mc(op_mc), .op_mp(op_mp),
    .spm_mc(spm_mc), .spm_mp(spm_mp), .spm_start(spm_start), .spm_prod_sel(spm_prod_sel),
    .spm_done(spm_done), .spm_prod(spm_prod),
    .res_valid(res_valid), .res_ready(res_ready), .res_prod(res_prod), .res_timeout(res_timeout),
    .busy(busy), .fifo_count(fifo_count), .job_count(job_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SPM: product computed at start, done raised 'lat' cycles after the
  // start cycle and held until the next start (stale_mode keeps the old done one extra cycle).
  always @(posedge clk) begin
    if (spm_start) begin
      spm_prod_r <= {32'd0, spm_mc} * {32'd0, spm_mp};
      cur_lat    <= rand_lat ? int'($urandom_range(40, 2)) : lat;
      spm_cnt    <= 1;
      if (!stale_mode) spm_done <= 1'b0;
    end else if (spm_cnt != 0) begin
      if (cur_lat != 0 && spm_cnt == cur_lat - 1) begin
        spm_done <= 1'b1;
        spm_cnt  <= 0;
      end else begin
        if (spm_cnt == 1) spm_done <= 1'b0;
        spm_cnt <= spm_cnt + 1;
      end
    end
  end
  assign spm_prod = spm_prod_sel ? spm_prod_r[63:32] : spm_prod_r[31:0];

  // Reference model: every accepted operand pair yields one expected result.
  always @(negedge clk) begin
    if (!rst) begin
      if (op_valid && op_ready && !clear) begin
        mon_e.to   = (lat == 0 && !rand_lat);
        mon_e.prod = mon_e.to ? 64'd0 : {32'd0, op_mc} * {32'd0, op_mp};
        exp_q.push_back(mon_e);
      end
      if (spm_start === 1'b1) n_starts++;
      if (spm_prod_sel === 1'b1) begin
        n_sel++;
        if (t_sel_first < 0) t_sel_first = cyc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, n_checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; op_valid = 1'b0; clear = 1'b0; res_ready = 1'b1;
    stale_mode = 1'b0; rand_lat = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  // Waits (bounded) for spm_start / res_valid / spm_prod_sel at a negedge; t = cycle index.
  task automatic wait_for(input int which, input int budget, input string name, output int t);
    bit hit = 1'b0;
    t = -1;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = (spm_start === 1'b1);
        1:       hit = (res_valid === 1'b1);
        default: hit = (spm_prod_sel === 1'b1);
      endcase
    end
    if (hit) t = cyc;
    else begin
      n_checks++; n_errors++;
      $display("FAIL wait_%s: event absent after %0d cycles", name, budget);
    end
  endtask

  // Offers one operand pair; returns just after the accepting edge with op_valid still high.
  task automatic push_op(input logic [31:0] mc, input logic [31:0] mp);
    bit ok = 1'b0;
    op_valid = 1'b1; op_mc = mc; op_mp = mp;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (op_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL push_op: op_ready never rose");
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({op_ready, res_valid, busy, spm_start, spm_prod_sel, res_timeout} !== 6'b100000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b exp 100000",
               {op_ready, res_valid, busy, spm_start, spm_prod_sel, res_timeout});
    end
    n_checks++;
    if (fifo_count !== '0 || job_count !== 16'd0 || timeout_count !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_counts: fifo=%0d jobs=%0d to=%0d exp 0", fifo_count, job_count, timeout_count);
    end
    n_checks++;
    if (spm_mc !== 32'd0 || spm_mp !== 32'd0 || res_prod !== 64'd0) begin
      n_errors++;
      $display("FAIL reset_data: mc=%h mp=%h prod=%h exp 0", spm_mc, spm_mp, res_prod);
    end
  endtask

  task automatic test_single();
    int t0, t1, s0;
    do_reset(); lat = 64; s0 = n_starts;
    push_op(32'd3, 32'd5); op_valid = 1'b0;
    wait_for(0, 20, "single_start", t0);
    wait_for(1, 200, "single_valid", t1);
    n_checks++;
    if (t1 - t0 != 69) begin n_errors++; $display("FAIL single_latency: got %0d exp 69", t1 - t0); end
    n_checks++;
    if (res_prod !== 64'h0000_0000_0000_000F || res_timeout !== 1'b0) begin
      n_errors++; $display("FAIL single_prod: got %h/%b exp 000000000000000f/0", res_prod, res_timeout);
    end
    @(negedge clk);
    n_checks++;
    if (job_count !== 16'd1 || res_valid !== 1'b0) begin
      n_errors++; $display("FAIL single_jobcount: got %0d valid=%b exp 1 valid=0", job_count, res_valid);
    end
    n_checks++;
    if (n_starts - s0 != 1) begin n_errors++; $display("FAIL single_starts: got %0d exp 1", n_starts - s0); end
  endtask

  task automatic test_full_product();
    int t0, t1, s0;
    do_reset(); lat = 64; t_sel_first = -1; s0 = n_sel;
    push_op(32'hFFFF_FFFF, 32'hFFFF_FFFF); op_valid = 1'b0;
    wait_for(0, 20, "full_start", t0);
    wait_for(1, 200, "full_valid", t1);
    n_checks++;
    if (res_prod !== 64'hFFFF_FFFE_0000_0001) begin
      n_errors++; $display("FAIL full_prod: got %h exp fffffffe00000001", res_prod);
    end
    n_checks++;
    if (t_sel_first != t0 + 64 + 3) begin
      n_errors++; $display("FAIL full_sel_order: prod_sel rose at %0d exp %0d", t_sel_first, t0 + 67);
    end
    n_checks++;
    if (n_sel - s0 != 2) begin n_errors++; $display("FAIL full_sel_cycles: got %0d exp 2", n_sel - s0); end
    @(negedge clk);
  endtask

  task automatic test_fifo_fill();
    int t;
    exp_t e;
    do_reset(); lat = 60; res_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_op($urandom, $urandom);
    op_mc = $urandom; op_mp = $urandom;      // a sixth pair keeps knocking
    @(negedge clk);
    n_checks++;
    if (fifo_count !== 3'd4 || op_ready !== 1'b0 || busy !== 1'b1) begin
      n_errors++; $display("FAIL fill_full: count=%0d ready=%b busy=%b exp 4/0/1", fifo_count, op_ready, busy);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (fifo_count !== 3'd4 || op_ready !== 1'b0) begin
      n_errors++; $display("FAIL fill_hold: count=%0d ready=%b exp 4/0", fifo_count, op_ready);
    end
    @(posedge clk); #1 op_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_for(1, 300, "fill_valid", t);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++; $display("FAIL fill_order: result %0d with empty model queue", k);
      end else begin
        e = exp_q.pop_front();
        if (res_prod !== e.prod || res_timeout !== e.to) begin
          n_errors++; $display("FAIL fill_order: result %0d got %h exp %h", k, res_prod, e.prod);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (job_count !== 16'd5) begin n_errors++; $display("FAIL fill_jobs: got %0d exp 5", job_count); end
  endtask

  task automatic test_timeout();
    int t0, t1;
    do_reset(); lat = 0;
    push_op(32'd7, 32'd9); op_valid = 1'b0;
    wait_for(0, 20, "to_start", t0);
    wait_for(1, 200, "to_valid", t1);
    n_checks++;
    if (t1 - t0 != TIMEOUT) begin n_errors++; $display("FAIL to_latency: got %0d exp %0d", t1 - t0, TIMEOUT); end
    n_checks++;
    if (res_timeout !== 1'b1 || res_prod !== 64'd0) begin
      n_errors++; $display("FAIL to_result: got %b/%h exp 1/0", res_timeout, res_prod);
    end
    @(negedge clk);
    n_checks++;
    if (timeout_count !== 8'd1 || job_count !== 16'd0) begin
      n_errors++; $display("FAIL to_counts: to=%0d jobs=%0d exp 1/0", timeout_count, job_count);
    end
    lat = 64;
  endtask

  task automatic test_stale_backpressure();
    int t0, t1;
    logic [63:0] exp_p;
    do_reset(); lat = 10;
    push_op(32'h1234, 32'h5678); op_valid = 1'b0;
    wait_for(1, 100, "stale_first", t1);
    @(negedge clk);
    @(posedge clk); #1;
    stale_mode = 1'b1; lat = 20; res_ready = 1'b0;
    exp_p = 64'h0000_0000_DEAD_BEEF * 64'h0000_0000_0BAD_F00D;
    push_op(32'hDEAD_BEEF, 32'h0BAD_F00D); op_valid = 1'b0;
    wait_for(0, 20, "stale_start", t0);
    wait_for(1, 200, "stale_valid", t1);
    n_checks++;
    if (t1 - t0 != 25) begin n_errors++; $display("FAIL stale_latency: got %0d exp 25", t1 - t0); end
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || res_prod !== exp_p) begin
        n_errors++; $display("FAIL stall_hold: cycle %0d valid=%b prod=%h exp 1/%h", i, res_valid, res_prod, exp_p);
      end
    end
    n_checks++;
    if (job_count !== 16'd1) begin n_errors++; $display("FAIL stall_jobs: got %0d exp 1", job_count); end
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (job_count !== 16'd2 || res_valid !== 1'b0) begin
      n_errors++; $display("FAIL stall_release: jobs=%0d valid=%b exp 2/0", job_count, res_valid);
    end
    stale_mode = 1'b0;
  endtask

  task automatic test_clear_reset();
    int t, bad;
    do_reset(); lat = 10;
    push_op(32'd11, 32'd13); op_valid = 1'b0;
    wait_for(1, 100, "clr_first", t);
    @(negedge clk);
    @(posedge clk); #1 lat = 0;
    for (int i = 0; i < 3; i++) push_op($urandom, $urandom);
    op_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fifo_count !== 3'd2 || busy !== 1'b1) begin
      n_errors++; $display("FAIL clr_pre: count=%0d busy=%b exp 2/1", fifo_count, busy);
    end
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || fifo_count !== '0 || res_valid !== 1'b0 || spm_start !== 1'b0) begin
      n_errors++; $display("FAIL clr_flush: busy=%b count=%0d valid=%b start=%b exp 0", busy, fifo_count, res_valid, spm_start);
    end
    n_checks++;
    if (job_count !== 16'd1) begin n_errors++; $display("FAIL clr_keep: jobs=%0d exp 1", job_count); end
    exp_q.delete();
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || spm_start !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL clr_quiet: %0d active cycles exp 0", bad); end
    @(posedge clk); #1 lat = 10;
    push_op(32'd21, 32'd23); op_valid = 1'b0;
    wait_for(2, 100, "rst_rdhi", t);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({spm_prod_sel, busy, res_valid, spm_start, res_timeout} !== 5'b0 || op_ready !== 1'b1) begin
      n_errors++; $display("FAIL rst_async_flags: sel=%b busy=%b valid=%b start=%b ready=%b",
                           spm_prod_sel, busy, res_valid, spm_start, op_ready);
    end
    n_checks++;
    if (spm_mc !== 32'd0 || spm_mp !== 32'd0 || job_count !== 16'd0 || res_prod !== 64'd0 || fifo_count !== '0) begin
      n_errors++; $display("FAIL rst_async_data: mc=%h mp=%h jobs=%0d prod=%h count=%0d",
                           spm_mc, spm_mp, job_count, res_prod, fifo_count);
    end
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_random();
    int got = 0;
    do_reset(); rand_lat = 1'b1; lat = 1;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(3, 0)) @(posedge clk);
          #1;
          push_op($urandom, $urandom);
          op_valid = 1'b0;
        end
      end
      begin
        for (int c = 0; c < 4000 && got < 12; c++) begin
          @(posedge clk); #1;
          res_ready = ($urandom_range(3, 0) != 0);
          @(negedge clk);
          if (res_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_errors++; $display("FAIL rand_result: unexpected result %h", res_prod);
            end else if (res_prod !== exp_q[0].prod || res_timeout !== exp_q[0].to) begin
              n_errors++; $display("FAIL rand_result: job %0d got %h/%b exp %h/%b",
                                   got, res_prod, res_timeout, exp_q[0].prod, exp_q[0].to);
            end
            if (res_ready) begin
              if (exp_q.size() != 0) void'(exp_q.pop_front());
              got++;
            end
          end
        end
      end
    join
    res_ready = 1'b1;
    n_checks++;
    if (got != 12) begin n_errors++; $display("FAIL rand_count: got %0d results exp 12", got); end
    @(negedge clk);
    n_checks++;
    if (job_count !== 16'd12 || timeout_count !== 8'd0) begin
      n_errors++; $display("FAIL rand_counters: jobs=%0d to=%0d exp 12/0", job_count, timeout_count);
    end
    rand_lat = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_single();
    test_full_product();
    test_fifo_fill();
    test_timeout();
    test_stale_backpressure();
    test_clear_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
